// File: rtl/pkcs1_v15_pad_pkg.sv
// Shared constants, state encoding and LFSR step function for the PKCS#1 v1.5 padder.
package pkcs1_pkg;

  localparam int          DEFAULT_WIDTH = 2048;
  localparam int          K             = DEFAULT_WIDTH / 8;
  localparam int          MAX_MLEN      = K - 11;
  localparam int          MIN_PS        = 8;
  localparam logic [7:0]  BT_ENCRYPT    = 8'h02;
  localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED  = 32'h1ACE_B00C;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    DRAIN,
    PAD,
    HOLD
  } state_t;

  // One right-shifting Galois step for x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsrNext(input logic [31:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/pkcs1_v15_pad_lfsr.sv
// 32-bit Galois LFSR supplying the pseudo-random padding-string octets.
module lfsr32_galois
  import pkcs1_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  logic [31:0] lfsr_q;

  // Reset to SEED; a load wins over stepping, and a zero seed would lock the register so SEED replaces it.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else if (load) begin
      lfsr_q <= (seed == 32'h0) ? SEED : seed;
    end else if (step) begin
      lfsr_q <= lfsrNext(lfsr_q);
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/pkcs1_v15_pad.sv
// EME-PKCS1-v1_5 encryption padding: collects M, fills nonzero PS from the LFSR, holds EM until acked.
module pkcs1_v15_pad
  import pkcs1_pkg::*;
#(
  parameter int          DATA_BIT_WIDTH = 2048,
  parameter logic [31:0] SEED           = 32'h1ACE_B00C
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                s_data,
  input  logic                      s_valid,
  input  logic                      s_last,
  output logic                      s_ready,
  input  logic                      seed_load,
  input  logic [31:0]               seed,
  output logic [DATA_BIT_WIDTH-1:0] em,
  output logic                      em_valid,
  input  logic                      em_ack,
  output logic                      err
);

  localparam int kOctets = DATA_BIT_WIDTH / 8;
  localparam int CW      = $clog2(kOctets + 1);
  localparam logic [CW-1:0] maxMlen = CW'(kOctets - 11);
  localparam logic [CW-1:0] psBase  = CW'(kOctets - 3);

  state_t                    state_q;
  logic [DATA_BIT_WIDTH-1:0] emReg_q;
  logic [CW-1:0]             mlen_q;
  logic [CW-1:0]             psIdx_q;
  logic                      err_q;
  logic                      emValid_q;

  logic [31:0]   lfsrQ;
  logic [7:0]    psByte;
  logic [CW-1:0] psPos;
  logic [CW-1:0] psLast;
  logic          lfsrLoad;
  logic          unusedLfsrBits;

  // Seeds are only taken while idle so a reseed can never disturb a padding string in progress.
  assign lfsrLoad = seed_load && (state_q == IDLE);

  lfsr32_galois #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsrLoad),
    .seed  (seed),
    .step  (1'b1),
    .q     (lfsrQ)
  );

  assign psByte         = lfsrQ[7:0];
  assign unusedLfsrBits = ^lfsrQ[31:8];

  // PS octet j sits just above the 0x00 separator at LSB-relative index mlen; psLast is the final j.
  assign psPos  = mlen_q + psIdx_q + CW'(1);
  assign psLast = psBase - mlen_q - CW'(1);

  // Main control: message collection, overflow drain, PS fill and hold-until-ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      emReg_q   <= '0;
      mlen_q    <= '0;
      psIdx_q   <= '0;
      err_q     <= 1'b0;
      emValid_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          emReg_q <= '0;
          mlen_q  <= '0;
          psIdx_q <= '0;
          if (s_valid) begin
            emReg_q <= {{(DATA_BIT_WIDTH-8){1'b0}}, s_data};
            mlen_q  <= CW'(1);
            state_q <= s_last ? PAD : COLLECT;
          end
        end
        COLLECT: begin
          if (s_valid) begin
            if (mlen_q == maxMlen) begin
              err_q   <= s_last;
              emReg_q <= '0;
              state_q <= s_last ? IDLE : DRAIN;
            end else begin
              emReg_q <= {emReg_q[DATA_BIT_WIDTH-9:0], s_data};
              mlen_q  <= mlen_q + CW'(1);
              if (s_last) begin
                state_q <= PAD;
              end
            end
          end
        end
        DRAIN: begin
          if (s_valid && s_last) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        PAD: begin
          if (psByte != 8'h00) begin
            emReg_q[8*psPos +: 8] <= psByte;
            if (psIdx_q == psLast) begin
              emReg_q[DATA_BIT_WIDTH-9 -: 8] <= BT_ENCRYPT;
              emValid_q <= 1'b1;
              state_q   <= HOLD;
            end else begin
              psIdx_q <= psIdx_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (em_ack) begin
            emValid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // s_ready is decoded from state and gated by reset so it is low during reset yet high the first cycle after.
  assign s_ready  = !reset && ((state_q == IDLE) || (state_q == COLLECT) || (state_q == DRAIN));
  assign em       = emReg_q;
  assign em_valid = emValid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_pkcs1_v15_pad.sv
// Self-checking bench for pkcs1_v15_pad: reference LFSR model plus a scoreboard of expected EM words.
module tb_pkcs1_v15_pad;

  localparam int          W     = 2048;
  localparam int          KB    = W / 8;
  localparam logic [31:0] SEEDV = 32'h1ACE_B00C;
  localparam logic [31:0] TAPS  = 32'h8020_0003;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic         seed_load;
  logic [31:0]  seed;
  logic [W-1:0] em;
  logic         em_valid;
  logic         em_ack;
  logic         err;

  int           checks  = 0;
  int           fails   = 0;
  int           errSeen = 0;
  int           errBase;
  int           zc;
  logic [31:0]  mLfsr;
  logic [7:0]   msg[$];
  logic [W-1:0] emQ[$];
  int           latQ[$];
  logic [W-1:0] lastExp;

  pkcs1_v15_pad #(
    .DATA_BIT_WIDTH (W),
    .SEED           (SEEDV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .seed_load (seed_load),
    .seed      (seed),
    .em        (em),
    .em_valid  (em_valid),
    .em_ack    (em_ack),
    .err       (err)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  function automatic logic [31:0] stepModel(input logic [31:0] v);
    logic [31:0] n;
    n = {1'b0, v[31:1]};
    if (v[0]) n = n ^ TAPS;
    return n;
  endfunction

  // Reference LFSR tracking the DUT cycle by cycle; the bench only raises seed_load while the DUT is idle.
  always @(posedge clk) begin
    if (reset) mLfsr <= SEEDV;
    else if (seed_load) mLfsr <= (seed == 32'h0) ? SEEDV : seed;
    else mLfsr <= stepModel(mLfsr);
  end

  // Count every cycle err is high so pulse width and spurious pulses are both visible.
  always @(posedge clk) begin
    if (err === 1'b1) errSeen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chkEm(input string tag, input logic [W-1:0] expv);
    int idx;
    idx = -1;
    checks++;
    assert (em === expv) else begin
      fails++;
      for (int i = KB - 1; i >= 0; i--) begin
        if (idx < 0 && em[8*i +: 8] !== expv[8*i +: 8]) idx = i;
      end
      if (idx < 0) idx = 0;
      $error("[TB] FAIL %s: octet %0d observed %h expected %h", tag, idx, em[8*idx +: 8], expv[8*idx +: 8]);
    end
  endtask

  // Build the expected EM and HOLD latency from the model LFSR as the last byte is about to transfer.
  task automatic pushExpected();
    logic [W-1:0] e;
    logic [31:0]  v;
    int mlen, psLen, z, j;
    e     = '0;
    v     = stepModel(mLfsr);
    mlen  = msg.size();
    psLen = KB - 3 - mlen;
    z     = 0;
    j     = 0;
    for (int i = 0; i < mlen; i++) e[8*(mlen-1-i) +: 8] = msg[i];
    while (j < psLen) begin
      if (v[7:0] != 8'h00) begin
        e[8*(mlen+1+j) +: 8] = v[7:0];
        j++;
      end else begin
        z++;
      end
      v = stepModel(v);
    end
    e[8*(KB-2) +: 8] = 8'h02;
    emQ.push_back(e);
    latQ.push_back(1 + psLen + z);
  endtask

  // Stream msg into the DUT one byte per accepted cycle; returns at the falling edge after the last transfer.
  task automatic applyStimulus(input bit expectEm);
    int n;
    int guard;
    n = msg.size();
    for (int i = 0; i < n; i++) begin
      s_data  = msg[i];
      s_valid = 1'b1;
      s_last  = (i == n - 1);
      guard   = 0;
      while (s_ready !== 1'b1 && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (s_ready !== 1'b1) begin
        chk("s_ready wait", {31'b0, s_ready}, 32'd1);
        break;
      end
      if (s_last && expectEm) pushExpected();
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
  endtask

  // Wait (bounded) for em_valid, then compare latency and the full EM against the scoreboard head.
  task automatic checkOutput(input string tag);
    int lat;
    int cyc;
    lat     = 0;
    lastExp = '0;
    if (emQ.size() > 0) begin
      lastExp = emQ.pop_front();
      lat     = latQ.pop_front();
    end
    cyc = 1;
    while (em_valid !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, cyc, lat);
    chkEm({tag, " em"}, lastExp);
  endtask

  // Keep the word in HOLD for a while, then pulse em_ack and confirm the return to IDLE.
  task automatic releaseEm(input string tag, input int hold);
    int bad;
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (em !== lastExp || em_valid !== 1'b1 || s_ready !== 1'b0) bad++;
    end
    if (hold > 0) chk({tag, " hold stable"}, bad, 0);
    chk({tag, " s_ready in hold"}, {31'b0, s_ready}, 32'd0);
    em_ack = 1'b1;
    @(negedge clk);
    em_ack = 1'b0;
    chk({tag, " em_valid after ack"}, {31'b0, em_valid}, 32'd0);
    chk({tag, " s_ready after ack"}, {31'b0, s_ready}, 32'd1);
  endtask

  // Directed sequence of scenarios, ending in the single summary line.
  initial begin
    reset     = 1'b1;
    s_data    = 8'h00;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    seed_load = 1'b0;
    seed      = 32'h0;
    em_ack    = 1'b0;

    repeat (2) @(negedge clk);
    chkEm("reset em", '0);
    chk("reset em_valid", {31'b0, em_valid}, 32'd0);
    chk("reset err", {31'b0, err}, 32'd0);
    chk("reset s_ready", {31'b0, s_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("s_ready after reset", {31'b0, s_ready}, 32'd1);
    @(negedge clk);

    $display("[TB] two-byte message with seed 1");
    seed      = 32'h0000_0001;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    seed      = 32'h0;
    msg = {8'hDE, 8'hAD};
    applyStimulus(1'b1);
    checkOutput("dead");
    chk("dead message octets", {16'h0, em[15:0]}, 32'h0000_DEAD);
    chk("dead separator", {24'h0, em[23:16]}, 32'h0);
    chk("dead block type", {24'h0, em[2039:2032]}, 32'h02);
    chk("dead leading zero", {24'h0, em[2047:2040]}, 32'h0);
    zc = 0;
    for (int i = 3; i < KB - 2; i++) if (em[8*i +: 8] == 8'h00) zc++;
    chk("dead ps nonzero", zc, 0);
    releaseEm("dead", 0);

    $display("[TB] maximum-length 245-byte message");
    msg.delete();
    for (int i = 1; i <= 245; i++) msg.push_back(8'(i));
    errBase = errSeen;
    applyStimulus(1'b1);
    checkOutput("max");
    chk("max no err", errSeen - errBase, 0);
    releaseEm("max", 0);

    $display("[TB] 246-byte message, zero seed reload");
    seed      = 32'h0;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    msg.delete();
    for (int i = 1; i <= 246; i++) msg.push_back(8'(i));
    errBase = errSeen;
    applyStimulus(1'b0);
    chk("246 err pulse", {31'b0, err}, 32'd1);
    chk("246 s_ready", {31'b0, s_ready}, 32'd1);
    chk("246 em_valid", {31'b0, em_valid}, 32'd0);
    @(negedge clk);
    chk("246 err drop", {31'b0, err}, 32'd0);
    chk("246 err count", errSeen - errBase, 1);
    msg = {8'h7E};
    applyStimulus(1'b1);
    checkOutput("after246");
    releaseEm("after246", 0);

    $display("[TB] 300-byte message drained");
    msg.delete();
    for (int i = 0; i < 300; i++) msg.push_back(8'(i * 7 + 3));
    errBase = errSeen;
    applyStimulus(1'b0);
    chk("300 err pulse", {31'b0, err}, 32'd1);
    chk("300 em_valid", {31'b0, em_valid}, 32'd0);
    @(negedge clk);
    chk("300 err count", errSeen - errBase, 1);

    $display("[TB] long hold before ack");
    msg = {8'hA5, 8'h5A, 8'hC3};
    applyStimulus(1'b1);
    checkOutput("hold");
    releaseEm("hold", 600);

    $display("[TB] reset during padding");
    msg = {8'h11, 8'h22, 8'h33, 8'h44};
    applyStimulus(1'b1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chkEm("padreset em", '0);
    chk("padreset em_valid", {31'b0, em_valid}, 32'd0);
    chk("padreset err", {31'b0, err}, 32'd0);
    chk("padreset s_ready", {31'b0, s_ready}, 32'd0);
    emQ.delete();
    latQ.delete();
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1);
    checkOutput("postreset");
    releaseEm("postreset", 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
